// File: rtl/multiplicador_datapath_ram.sv
// multiplicador_datapath_ram: shift-and-add datapath driven by the RAM multiplier controller state.
// Optional feature macro: MULT_SIGNED_EN (two's-complement operands, BIT3 subtracts).
module multiplicador_datapath_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [2:0]        state_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    input  logic [7:0]        ram_rdata_i,
    output logic              res_we_o,
    output logic [ADDR_W-1:0] res_addr_o,
    output logic [7:0]        res_wdata_o,
    output logic [7:0]        product_o,
    output logic              done_o,
    output logic              wrap_o
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_BIT0 = 3'd1;
    localparam logic [2:0] S_BIT3 = 3'd4;
    localparam logic [2:0] S_END  = 3'd5;

    logic [ADDR_W-1:0] ptr;
    logic [7:0]        acc, ext, addend, next_acc;
    logic [3:0]        mcand, mplier;
    logic [2:0]        prev_state;
    logic [1:0]        k;
    logic              is_idle, is_bit, first_end, last;

    // Decode the controller state and form the partial product for the current bit.
    always_comb begin
        k         = 2'(state_i - S_BIT0);
        is_idle   = (state_i == S_IDLE) || (state_i > S_END);
        is_bit    = (state_i >= S_BIT0) && (state_i <= S_BIT3);
        first_end = (state_i == S_END) && (prev_state != S_END);
        last      = ptr == ADDR_W'(DEPTH - 1);
`ifdef MULT_SIGNED_EN
        ext       = {{4{mcand[3]}}, mcand};
        addend    = ext << k;
        next_acc  = (k == 2'd3) ? acc - addend : acc + addend;
`else
        ext       = {4'b0, mcand};
        addend    = ext << k;
        next_acc  = acc + addend;
`endif
    end

    assign ram_addr_o  = ptr;
    assign res_addr_o  = ptr;
    assign res_wdata_o = acc;
    assign res_we_o    = first_end;
    assign done_o      = first_end;
    assign wrap_o      = first_end && last;

    // Operand capture, accumulation and per-product pointer advance.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr        <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            prev_state <= S_IDLE;
            product_o  <= '0;
        end else begin
            prev_state <= state_i;
            if (is_idle) begin
                mcand  <= ram_rdata_i[7:4];
                mplier <= ram_rdata_i[3:0];
                acc    <= '0;
            end else if (is_bit && mplier[k]) begin
                acc <= next_acc;
            end
            if (first_end) begin
                product_o <= acc;
                ptr       <= last ? '0 : ptr + ADDR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_multiplicador_datapath_ram.sv
// tb_multiplicador_datapath_ram: randomized passes checked against a product-level model.
module tb_multiplicador_datapath_ram;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk_i = 0;
    logic              rst_i = 0;
    logic [2:0]        state_i = 3'd0;
    logic [ADDR_W-1:0] ram_addr_o, res_addr_o;
    logic [7:0]        ram_rdata_i = 8'h00;
    logic              res_we_o, done_o, wrap_o;
    logic [7:0]        res_wdata_o, product_o;

    multiplicador_datapath_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .state_i(state_i),
        .ram_addr_o(ram_addr_o), .ram_rdata_i(ram_rdata_i),
        .res_we_o(res_we_o), .res_addr_o(res_addr_o), .res_wdata_o(res_wdata_o),
        .product_o(product_o), .done_o(done_o), .wrap_o(wrap_o)
    );

    always #5 clk_i = ~clk_i;

    logic [7:0] mem [DEPTH];
    always @(posedge clk_i) ram_rdata_i <= mem[ram_addr_o];

    int tests = 0, fails = 0;
    int m_ptr = 0;
    logic [7:0] m_prod = 8'h00, exp_data = 8'h00;
    logic exp_we = 0, pending = 0, run = 0;
    int we_cnt = 0, done_cnt = 0, wrap_cnt = 0;
    logic [7:0] last_wdata = 8'h00;
    int last_waddr = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] prod(input logic [7:0] w);
        int a, b;
`ifdef MULT_SIGNED_EN
        a = $signed(w[7:4]);
        b = $signed(w[3:0]);
`else
        a = int'(w[7:4]);
        b = int'(w[3:0]);
`endif
        return 8'(a * b);
    endfunction

    // Compare DUT outputs against the model every cycle, away from the clock edge.
    always @(negedge clk_i) if (run) begin
        chk("we", 32'(res_we_o), 32'(exp_we));
        chk("done", 32'(done_o), 32'(exp_we));
        chk("wrap", 32'(wrap_o), 32'(exp_we && m_ptr == DEPTH - 1));
        chk("ram_addr", 32'(ram_addr_o), 32'(m_ptr));
        chk("res_addr", 32'(res_addr_o), 32'(m_ptr));
        chk("product", 32'(product_o), 32'(m_prod));
        if (exp_we) chk("wdata", 32'(res_wdata_o), 32'(exp_data));
        if (res_we_o) begin
            we_cnt++;
            last_wdata = res_wdata_o;
            last_waddr = int'(res_addr_o);
        end
        if (done_o) done_cnt++;
        if (wrap_o) wrap_cnt++;
    end

    task automatic step(input logic [2:0] st, input logic we);
        @(posedge clk_i);
        #1;
        if (pending) begin
            m_prod  = exp_data;
            m_ptr   = (m_ptr + 1) % DEPTH;
            pending = 0;
        end
        state_i = st;
        exp_we  = we;
        if (we) pending = 1;
    endtask

    task automatic run_pass(input int idle_n, input int end_n);
        for (int i = 0; i < idle_n; i++)
            step(($urandom_range(0, 3) == 0) ? 3'($urandom_range(6, 7)) : 3'd0, 0);
        exp_data = prod(mem[m_ptr]);
        for (int b = 1; b <= 4; b++) step(3'(b), 0);
        step(3'd5, 1);
        for (int i = 1; i < end_n; i++) step(3'd5, 0);
    endtask

    task automatic hard_reset();
        step(3'd0, 0);
        rst_i   = 0;
        m_ptr   = 0;
        m_prod  = 8'h00;
        pending = 0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w0, d0, wp;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
`ifdef MULT_SIGNED_EN
        mem[0] = 8'hD5; mem[1] = 8'h88; mem[2] = 8'h09;
`else
        mem[0] = 8'h35; mem[1] = 8'hFF; mem[2] = 8'h09;
`endif
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1;
        run   = 1;
        chk("reset_product", 32'(product_o), 32'h0);
        chk("reset_addr", 32'(ram_addr_o), 32'h0);
        run_pass(3, 1);
        step(3'd0, 0);
`ifdef MULT_SIGNED_EN
        chk("signed_d5_data", 32'(last_wdata), 32'hF1);
        chk("signed_d5_addr", 32'(last_waddr), 32'd0);
        chk("signed_d5_product", 32'(product_o), 32'hF1);
        run_pass(2, 1);
        step(3'd0, 0);
        chk("signed_88_data", 32'(last_wdata), 32'h40);
        chk("signed_88_addr", 32'(last_waddr), 32'd1);
        run_pass(2, 1);
        step(3'd0, 0);
        chk("signed_09_data", 32'(last_wdata), 32'h00);
`else
        chk("t1_data", 32'(last_wdata), 32'h0F);
        chk("t1_addr", 32'(last_waddr), 32'd0);
        chk("t1_product", 32'(product_o), 32'h0F);
        chk("t1_ptr", 32'(ram_addr_o), 32'd1);
        run_pass(2, 1);
        step(3'd0, 0);
        chk("t2_ff_data", 32'(last_wdata), 32'hE1);
        chk("t2_ff_addr", 32'(last_waddr), 32'd1);
        run_pass(2, 1);
        step(3'd0, 0);
        chk("t2_09_data", 32'(last_wdata), 32'h00);
        chk("t2_09_addr", 32'(last_waddr), 32'd2);
`endif
        w0 = we_cnt; d0 = done_cnt;
        run_pass(2, 5);
        step(3'd0, 0);
        chk("t3_one_write", 32'(we_cnt - w0), 32'd1);
        chk("t3_one_done", 32'(done_cnt - d0), 32'd1);
        for (int n = 0; n < 40; n++) begin
            run_pass($urandom_range(2, 4), $urandom_range(1, 4));
            mem[(m_ptr + 5) % DEPTH] = 8'($urandom);
        end
`ifdef MULT_SIGNED_EN
        mem[0] = 8'hD5;
`else
        mem[0] = 8'h35;
`endif
        w0 = we_cnt;
        for (int i = 0; i < 3; i++) step(3'd0, 0);
        step(3'd1, 0); step(3'd2, 0); step(3'd3, 0);
        #2;
        rst_i   = 0;
        state_i = 3'd0;
        m_ptr   = 0;
        m_prod  = 8'h00;
        pending = 0;
        #1;
        chk("async_reset_addr", 32'(ram_addr_o), 32'd0);
        chk("async_reset_product", 32'(product_o), 32'h0);
        chk("async_reset_we", 32'(res_we_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1;
        chk("t5_no_write", 32'(we_cnt - w0), 32'd0);
        run_pass(2, 1);
        step(3'd0, 0);
`ifdef MULT_SIGNED_EN
        chk("t5_data", 32'(last_wdata), 32'hF1);
`else
        chk("t5_data", 32'(last_wdata), 32'h0F);
`endif
        chk("t5_addr", 32'(last_waddr), 32'd0);
        hard_reset();
        wp = -1;
        w0 = wrap_cnt;
        for (int p = 0; p < DEPTH; p++) begin
            d0 = wrap_cnt;
            run_pass(2, 1);
            step(3'd0, 0);
            if (wrap_cnt != d0) wp = p;
        end
        chk("t4_wrap_count", 32'(wrap_cnt - w0), 32'd1);
        chk("t4_wrap_pass", 32'(wp), 32'(DEPTH - 1));
        chk("t4_ptr_back", 32'(ram_addr_o), 32'd0);
        step(3'd0, 0);
        run = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
